// File: rtl/mcyc_ctrl.sv
// mcyc_ctrl: multi-cycle EX sequencer (MAC / divide) and per-stage pipeline stall merger.
// Latency: start in the request cycle, N step cycles, done one cycle later; divide-by-zero done next cycle.
// Backpressure: holds PC/IF/ID/EX via stall_o while the EX op runs; flush drops everything at once.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   stallreq_id_i     decode-stage operand-hazard stall request
//   ex_mc_req_i       EX holds a multi-cycle instruction (level)
//   ex_mc_kind_i      0 = multiply-accumulate, 1 = divide (sampled in IDLE)
//   div_zero_i        divisor is zero (sampled in IDLE for divides)
//   flush_i           pipeline flush, highest priority
//   stall_o[5:0]      stall vector {WB,MEM,EX,ID,IF,PC}
//   mc_start_o        operand-load pulse for the HI/LO datapath
//   mc_step_o         datapath iterates this cycle
//   mc_cnt_o[5:0]     iteration index (0 outside RUN)
//   mc_busy_o         sequencer is in RUN
//   mc_done_o         result-valid pulse, EX releases
//   mc_dbz_o          divide-by-zero flag, valid with mc_done_o
//
// Build option: MCYC_DIV_ZERO_EN enables the divide-by-zero short-circuit
// (IDLE -> DONE with mc_dbz_o = 1). Without it div_zero_i is ignored and
// mc_dbz_o is always 0.

module mcyc_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_id_i,
  input  logic       ex_mc_req_i,
  input  logic       ex_mc_kind_i,
  input  logic       div_zero_i,
  input  logic       flush_i,
  output logic [5:0] stall_o,
  output logic       mc_start_o,
  output logic       mc_step_o,
  output logic [5:0] mc_cnt_o,
  output logic       mc_busy_o,
  output logic       mc_done_o,
  output logic       mc_dbz_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Final iteration index for each operation kind.
  localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES - 1);
  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;  // PC, IF, ID
  localparam logic [5:0] STALL_EX   = 6'b001111;  // PC, IF, ID, EX

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       kind_q, kind_d;
  logic       dbz_q, dbz_d;

  logic       dz_fast;
  logic       last_iter;
  logic       in_reset;

  // Divide-by-zero short-circuit decision, taken on the live inputs in IDLE.
`ifdef MCYC_DIV_ZERO_EN
  assign dz_fast = ex_mc_kind_i & div_zero_i;
`else
  logic unused_div_zero;
  assign unused_div_zero = div_zero_i;
  assign dz_fast         = 1'b0;
`endif

  // The counter runs 0..N-1 using the kind latched when the op started.
  assign last_iter = (cnt_q == (kind_q ? DIV_LAST : MUL_LAST));

  // Outputs that depend on live inputs must also read 0 while reset is held,
  // otherwise a request present during reset would leak through.
  assign in_reset = ~rst;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    dbz_d   = dbz_q;

    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = 6'd0;
      dbz_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ex_mc_req_i) begin
            kind_d = ex_mc_kind_i;
            cnt_d  = 6'd0;
            if (dz_fast) begin
              state_d = ST_DONE;
              dbz_d   = 1'b1;
            end else begin
              state_d = ST_RUN;
              dbz_d   = 1'b0;
            end
          end
        end

        ST_RUN: begin
          if (!ex_mc_req_i) begin
            // Instruction annulled while iterating: abandon without a done pulse.
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
          end else if (last_iter) begin
            state_d = ST_DONE;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end

        ST_DONE: begin
          // Single result cycle; a following instruction is picked up in IDLE.
          state_d = ST_IDLE;
          dbz_d   = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
          dbz_d   = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      kind_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      dbz_q   <= dbz_d;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath control outputs
  // ---------------------------------------------------------------------
  // Start is Mealy on the request so operands load in the same cycle EX
  // first presents the instruction.
  assign mc_start_o = ~in_reset & ~flush_i & (state_q == ST_IDLE) &
                      ex_mc_req_i & ~dz_fast;

  assign mc_step_o  = ~in_reset & ~flush_i & (state_q == ST_RUN);

  assign mc_busy_o  = (state_q == ST_RUN);

  assign mc_cnt_o   = (state_q == ST_RUN) ? cnt_q : 6'd0;

  assign mc_done_o  = ~in_reset & ~flush_i & (state_q == ST_DONE);

  assign mc_dbz_o   = mc_done_o & dbz_q;

  // ---------------------------------------------------------------------
  // Stall vector merge
  // ---------------------------------------------------------------------
  // In DONE the result is ready, so the EX hold drops and the instruction
  // advances on the edge closing that cycle.
  always_comb begin
    stall_o = STALL_NONE;
    if (in_reset || flush_i) begin
      stall_o = STALL_NONE;
    end else if (ex_mc_req_i && (state_q != ST_DONE)) begin
      stall_o = STALL_EX;
    end else if (stallreq_id_i) begin
      stall_o = STALL_ID;
    end
  end

endmodule

// File: tb/tb_mcyc_ctrl.sv
// tb_mcyc_ctrl: directed self-checking bench for mcyc_ctrl with default parameters
// (DIV_CYCLES = 32, MUL_CYCLES = 2). Inputs change 1 ns after the rising edge,
// outputs are sampled 3 ns after the rising edge.

module tb_mcyc_ctrl;

  logic       clk;
  logic       rst;
  logic       stallreq_id_i;
  logic       ex_mc_req_i;
  logic       ex_mc_kind_i;
  logic       div_zero_i;
  logic       flush_i;
  logic [5:0] stall_o;
  logic       mc_start_o;
  logic       mc_step_o;
  logic [5:0] mc_cnt_o;
  logic       mc_busy_o;
  logic       mc_done_o;
  logic       mc_dbz_o;

  int n_tests = 0;
  int n_fail  = 0;

  mcyc_ctrl #(
    .DIV_CYCLES(32),
    .MUL_CYCLES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id_i(stallreq_id_i),
    .ex_mc_req_i  (ex_mc_req_i),
    .ex_mc_kind_i (ex_mc_kind_i),
    .div_zero_i   (div_zero_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .mc_start_o   (mc_start_o),
    .mc_step_o    (mc_step_o),
    .mc_cnt_o     (mc_cnt_o),
    .mc_busy_o    (mc_busy_o),
    .mc_done_o    (mc_done_o),
    .mc_dbz_o     (mc_dbz_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Called in the request cycle t (inputs applied and settled); walks the
  // op through its N step cycles and the done cycle at t+N+1.
  task automatic run_op(input string tag, input int n, input logic exp_dbz);
    chk({tag, "_start"}, {31'd0, mc_start_o}, 32'd1);
    chk({tag, "_stall_t"}, {26'd0, stall_o}, 32'h0F);
    chk({tag, "_nostep_t"}, {31'd0, mc_step_o}, 32'd0);
    for (int i = 0; i < n; i++) begin
      nxt(); #2;
      chk({tag, "_step"}, {31'd0, mc_step_o}, 32'd1);
      chk({tag, "_busy"}, {31'd0, mc_busy_o}, 32'd1);
      chk({tag, "_cnt"}, {26'd0, mc_cnt_o}, i);
      chk({tag, "_stall_run"}, {26'd0, stall_o}, 32'h0F);
      chk({tag, "_nodone_run"}, {31'd0, mc_done_o}, 32'd0);
    end
    nxt(); #2;
    chk({tag, "_done"}, {31'd0, mc_done_o}, 32'd1);
    chk({tag, "_dbz"}, {31'd0, mc_dbz_o}, {31'd0, exp_dbz});
    chk({tag, "_stall_done"}, {26'd0, stall_o}, 32'h00);
    chk({tag, "_nostep_done"}, {31'd0, mc_step_o}, 32'd0);
    chk({tag, "_nobusy_done"}, {31'd0, mc_busy_o}, 32'd0);
    chk({tag, "_cnt_done"}, {26'd0, mc_cnt_o}, 32'd0);
    chk({tag, "_nostart_done"}, {31'd0, mc_start_o}, 32'd0);
  endtask

  initial begin
    // Reset held with live requests present: everything must read 0.
    rst           = 1'b0;
    stallreq_id_i = 1'b1;
    ex_mc_req_i   = 1'b1;
    ex_mc_kind_i  = 1'b1;
    div_zero_i    = 1'b0;
    flush_i       = 1'b0;
    #3;
    chk("rst_stall", {26'd0, stall_o}, 32'h00);
    chk("rst_start", {31'd0, mc_start_o}, 32'd0);
    chk("rst_step", {31'd0, mc_step_o}, 32'd0);
    chk("rst_busy", {31'd0, mc_busy_o}, 32'd0);
    chk("rst_cnt", {26'd0, mc_cnt_o}, 32'd0);
    chk("rst_done", {31'd0, mc_done_o}, 32'd0);
    chk("rst_dbz", {31'd0, mc_dbz_o}, 32'd0);

    // Release reset; decode hazard alone.
    @(posedge clk); @(posedge clk); #1;
    rst          = 1'b1;
    ex_mc_req_i  = 1'b0;
    ex_mc_kind_i = 1'b0;
    #2;
    chk("haz_only_stall", {26'd0, stall_o}, 32'h07);
    chk("haz_only_start", {31'd0, mc_start_o}, 32'd0);

    // New divide together with the hazard: EX hold takes priority.
    nxt();
    ex_mc_req_i  = 1'b1;
    ex_mc_kind_i = 1'b1;
    #2;
    chk("haz_prio_stall", {26'd0, stall_o}, 32'h0F);
    stallreq_id_i = 1'b0;
    #1;
    run_op("div", 32, 1'b0);
    nxt();
    ex_mc_req_i = 1'b0;
    #2;
    chk("div_after_done", {31'd0, mc_done_o}, 32'd0);
    chk("div_after_start", {31'd0, mc_start_o}, 32'd0);
    chk("div_after_stall", {26'd0, stall_o}, 32'h00);

    // Multiply-accumulate, then a back-to-back one (request held through DONE).
    nxt();
    ex_mc_req_i  = 1'b1;
    ex_mc_kind_i = 1'b0;
    #2;
    run_op("mul", 2, 1'b0);
    nxt(); #2;
    run_op("mul_b2b", 2, 1'b0);
    nxt();
    ex_mc_req_i = 1'b0;
    #2;
    chk("mul_after_busy", {31'd0, mc_busy_o}, 32'd0);
    chk("mul_after_done", {31'd0, mc_done_o}, 32'd0);

    // Divide by zero.
    nxt();
    ex_mc_req_i  = 1'b1;
    ex_mc_kind_i = 1'b1;
    div_zero_i   = 1'b1;
    #2;
`ifdef MCYC_DIV_ZERO_EN
    chk("dbz_nostart", {31'd0, mc_start_o}, 32'd0);
    chk("dbz_stall_t", {26'd0, stall_o}, 32'h0F);
    chk("dbz_nostep_t", {31'd0, mc_step_o}, 32'd0);
    nxt(); #2;
    chk("dbz_done", {31'd0, mc_done_o}, 32'd1);
    chk("dbz_flag", {31'd0, mc_dbz_o}, 32'd1);
    chk("dbz_stall_done", {26'd0, stall_o}, 32'h00);
    chk("dbz_busy", {31'd0, mc_busy_o}, 32'd0);
`else
    run_op("dbz_off", 32, 1'b0);
`endif
    nxt();
    ex_mc_req_i = 1'b0;
    div_zero_i  = 1'b0;
    #2;
    chk("dbz_after_done", {31'd0, mc_done_o}, 32'd0);
    chk("dbz_after_dbz", {31'd0, mc_dbz_o}, 32'd0);

    // Flush while the divide sits at counter 10.
    nxt();
    ex_mc_req_i  = 1'b1;
    ex_mc_kind_i = 1'b1;
    #2;
    chk("fl_start", {31'd0, mc_start_o}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      nxt(); #2;
      chk("fl_cnt", {26'd0, mc_cnt_o}, i);
    end
    nxt();
    flush_i = 1'b1;
    #2;
    chk("fl_cnt10", {26'd0, mc_cnt_o}, 32'd10);
    chk("fl_stall", {26'd0, stall_o}, 32'h00);
    chk("fl_step", {31'd0, mc_step_o}, 32'd0);
    chk("fl_start0", {31'd0, mc_start_o}, 32'd0);
    chk("fl_done0", {31'd0, mc_done_o}, 32'd0);
    nxt();
    flush_i     = 1'b0;
    ex_mc_req_i = 1'b0;
    #2;
    chk("fl_idle_busy", {31'd0, mc_busy_o}, 32'd0);
    chk("fl_idle_cnt", {26'd0, mc_cnt_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("fl_nodone", {31'd0, mc_done_o}, 32'd0);
      nxt(); #2;
    end

    // Annulment: request dropped while the divide sits at counter 5.
    ex_mc_req_i  = 1'b1;
    ex_mc_kind_i = 1'b1;
    #1;
    chk("an_start", {31'd0, mc_start_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      nxt(); #2;
      chk("an_cnt", {26'd0, mc_cnt_o}, i);
    end
    nxt();
    ex_mc_req_i = 1'b0;
    #2;
    chk("an_cnt5", {26'd0, mc_cnt_o}, 32'd5);
    chk("an_stall", {26'd0, stall_o}, 32'h00);
    for (int i = 0; i < 3; i++) begin
      nxt(); #2;
      chk("an_idle_busy", {31'd0, mc_busy_o}, 32'd0);
      chk("an_nodone", {31'd0, mc_done_o}, 32'd0);
    end

    // Reset asserted mid-RUN with the request still present.
    nxt();
    ex_mc_req_i  = 1'b1;
    ex_mc_kind_i = 1'b1;
    #2;
    chk("rr_start", {31'd0, mc_start_o}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      nxt(); #2;
      chk("rr_cnt", {26'd0, mc_cnt_o}, i);
    end
    #1;
    rst = 1'b0;
    #1;
    chk("rr_async_stall", {26'd0, stall_o}, 32'h00);
    chk("rr_async_step", {31'd0, mc_step_o}, 32'd0);
    chk("rr_async_busy", {31'd0, mc_busy_o}, 32'd0);
    chk("rr_async_cnt", {26'd0, mc_cnt_o}, 32'd0);
    chk("rr_async_start", {31'd0, mc_start_o}, 32'd0);
    chk("rr_async_done", {31'd0, mc_done_o}, 32'd0);
    nxt();
    rst         = 1'b1;
    ex_mc_req_i = 1'b0;
    #2;
    chk("rr_rel_busy", {31'd0, mc_busy_o}, 32'd0);
    chk("rr_rel_cnt", {26'd0, mc_cnt_o}, 32'd0);
    nxt();
    ex_mc_req_i  = 1'b1;
    ex_mc_kind_i = 1'b0;
    #2;
    run_op("rr_restart", 2, 1'b0);
    nxt();
    ex_mc_req_i = 1'b0;
    #2;
    chk("rr_end_busy", {31'd0, mc_busy_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mcyc_ctrl.md
# mcyc_ctrl

Multi-cycle execute sequencer and pipeline stall controller for the five-stage core. Tracks one in-flight multi-cycle EX operation (multiply-accumulate or divide) and drives the iteration enables of the shared HI/LO arithmetic datapath. Merges the EX hold with the decode-stage load-use stall request into the per-stage stall vector consumed by the PC and pipeline registers. Also cancels an in-flight operation on flush or annulment.

## Interface
- `DIV_CYCLES`, 32: RUN cycles for a divide, 1..63.
- `MUL_CYCLES`, 2: RUN cycles for a multiply-accumulate/subtract, 1..63.

- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-low (0 = reset).
- `stallreq_id_i`  input  1  decode-stage stall request (operand hazard).
- `ex_mc_req_i`  input  1  EX holds a multi-cycle instruction; level, held while it stays in EX.
- `ex_mc_kind_i`  input  1  0 = multiply-accumulate, 1 = divide; sampled in IDLE.
- `div_zero_i`  input  1  divisor is zero; sampled in IDLE when kind = 1.
- `flush_i`  input  1  pipeline flush (exception); highest priority.
- `stall_o`  output  6  stall vector, bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `mc_start_o`  output  1  one-cycle pulse: datapath loads operands.
- `mc_step_o`  output  1  datapath performs one iteration this cycle.
- `mc_cnt_o`  output  6  current iteration index.
- `mc_busy_o`  output  1  state is RUN.
- `mc_done_o`  output  1  one-cycle pulse: result valid, EX releases.
- `mc_dbz_o`  output  1  divide-by-zero result flag, valid with `mc_done_o`.

## Operation
- States: IDLE, RUN, DONE. Registered: state, 6-bit counter, kind, dbz flag.
- N = `MUL_CYCLES` when latched kind = 0, else `DIV_CYCLES`.
- IDLE:
  - With `ex_mc_req_i`=1 and `flush_i`=0: latch kind. Divide with `div_zero_i`=1 (macro on) → DONE with dbz set. Otherwise assert `mc_start_o`, clear counter, go to RUN.
- RUN:
  - `mc_step_o`=1, `mc_busy_o`=1, `mc_cnt_o`=counter; counter increments each cycle.
  - At counter = N-1 → DONE.
  - `ex_mc_req_i` dropping (annulled) → IDLE, no done.
- DONE: `mc_done_o`=1, `mc_dbz_o`=latched dbz, then unconditionally → IDLE. `ex_mc_req_i` is ignored here; the next instruction is sampled in the following IDLE cycle.
- `flush_i`=1 in any state → IDLE next edge. Counter cleared, no `mc_done_o`, `mc_start_o`/`mc_step_o` forced 0 that cycle.
- `mc_cnt_o` is 0 outside RUN. `mc_dbz_o` is 0 outside DONE.
- Stall vector (combinational), in priority order:
  - `flush_i` → 6'b000000.
  - `ex_mc_req_i`=1 and state ≠ DONE → 6'b001111.
  - `stallreq_id_i` → 6'b000111.
  - else 6'b000000.

## Timing
- Request first seen in IDLE at cycle t:
  - `mc_start_o` at t.
  - `mc_step_o` t+1..t+N.
  - `mc_done_o` at t+N+1.
  - EX stall asserted t..t+N (N+1 cycles); the instruction leaves EX on the edge ending t+N+1.
- Divide-by-zero fast path: stall at t only, `mc_done_o`+`mc_dbz_o` at t+1.
- Back-to-back multi-cycle instructions: the second is first seen in IDLE at t+N+2.
- Reset asserted: state IDLE, counter 0, every output 0 immediately (asynchronous), including `stall_o`.
- Reset mid-RUN: the operation is lost; after release a new request restarts at counter 0.

## Configuration
- `MCYC_DIV_ZERO_EN` defined: divide-by-zero short-circuits IDLE→DONE with `mc_dbz_o`=1.
- Undefined: `div_zero_i` is ignored, divides always run `DIV_CYCLES`, and `mc_dbz_o` is tied 0.

## Test plan
- Divide, `DIV_CYCLES`=32, req at t:
  - start at t, step t+1..t+32, `mc_cnt_o` 0..31.
  - done at t+33; `stall_o`=6'b001111 t..t+32, 6'b000000 at t+33.
- Multiply-accumulate, `MUL_CYCLES`=2, req at t: step t+1..t+2, done t+3, stall 3 cycles.
- Divide by zero:
  - macro defined: done=1 and dbz=1 at t+1, stall only at t.
  - macro undefined: timing as divide case, dbz=0.
- Flush at RUN counter 10: `stall_o`=0 that cycle, IDLE next cycle, no done pulse.
- Hazard priority: `stallreq_id_i`=1 alone → `stall_o`=6'b000111; together with a new `ex_mc_req_i` → 6'b001111.
- Reset and annulment:
  - `rst`=0 mid-RUN → all outputs 0 asynchronously; release plus req restarts with start pulse and counter 0.
  - `ex_mc_req_i` dropped mid-RUN → IDLE, no done.
